// File: rtl/icache_fill_ctrl.sv
// Direct-mapped I-cache with a 4-word line fill. Hits are combinational; misses
// stall the core while the line is streamed in with overlapped issue/receive.
module icache_fill_ctrl #(
    parameter int NUM_LINES = 8,
    parameter int MEM_LAT   = 1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        CORE_REQ,
    input  logic [11:0] CORE_ADDR,
    input  logic        FLUSH,
    output logic [31:0] CORE_INST,
    output logic        CORE_VALID,
    output logic        STALL,
    output logic        MEM_CSN,
    output logic [11:0] MEM_ADDR,
    input  logic [31:0] MEM_DI,
    output logic [15:0] HIT_CNT,
    output logic [15:0] MISS_CNT
);
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 8 - IW;
    localparam int CW = $clog2(MEM_LAT + 5);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t                 r_state;
    logic [NUM_LINES-1:0]   r_valid;
    logic [TW-1:0]          r_tag  [NUM_LINES];
    logic [31:0]            r_data [NUM_LINES][4];
    logic [7:0]             r_base;
    logic [CW-1:0]          r_cnt;
    logic                   r_flush_pend;
    logic                   r_csn;
    logic [11:0]            r_addr;
    logic [15:0]            r_hit_cnt;
    logic [15:0]            r_miss_cnt;

    logic [IW-1:0]          w_idx;
    logic [TW-1:0]          w_tag;
    logic [1:0]             w_word;
    logic                   w_hit;
    logic                   w_miss;
    logic [IW-1:0]          w_fidx;
    logic                   w_cap;
    logic [1:0]             w_cap_word;
    logic                   w_last;
    logic                   w_unused;

    assign w_idx    = CORE_ADDR[IW+3:4];
    assign w_tag    = CORE_ADDR[11:IW+4];
    assign w_word   = CORE_ADDR[3:2];
    assign w_unused = ^CORE_ADDR[1:0];

    // A flush in the lookup cycle forces a miss even if the line looked valid.
    assign w_hit  = RSTn && (r_state == S_IDLE) && CORE_REQ && !FLUSH
                    && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss = RSTn && (r_state == S_IDLE) && CORE_REQ && !w_hit;

    assign CORE_VALID = w_hit;
    assign CORE_INST  = w_hit ? r_data[w_idx][w_word] : 32'h0;
    assign STALL      = RSTn && ((r_state == S_FILL) || w_miss);
    assign MEM_CSN    = r_csn;
    assign MEM_ADDR   = r_addr;
    assign HIT_CNT    = r_hit_cnt;
    assign MISS_CNT   = r_miss_cnt;

    // r_cnt is the FILL cycle number; word k arrives MEM_LAT cycles after its issue.
    assign w_fidx     = r_base[IW-1:0];
    assign w_cap      = (r_state == S_FILL) && (r_cnt >= CW'(MEM_LAT));
    assign w_cap_word = 2'(r_cnt - CW'(MEM_LAT));
    assign w_last     = (r_state == S_FILL) && (r_cnt == CW'(MEM_LAT + 3));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_base       <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_csn        <= 1'b1;
            r_addr       <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (FLUSH)
                        r_valid <= '0;
                    if (w_miss) begin
                        r_base  <= CORE_ADDR[11:4];
                        r_addr  <= {CORE_ADDR[11:4], 4'h0};
                        r_csn   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_FILL;
                        if (r_miss_cnt != 16'hFFFF)
                            r_miss_cnt <= r_miss_cnt + 16'd1;
                    end else if (w_hit) begin
                        if (r_hit_cnt != 16'hFFFF)
                            r_hit_cnt <= r_hit_cnt + 16'd1;
                    end
                end
                S_FILL: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (FLUSH)
                        r_flush_pend <= 1'b1;
                    if (r_cnt < CW'(3)) begin
                        r_addr <= r_addr + 12'd4;
                        r_csn  <= 1'b0;
                    end else begin
                        r_csn  <= 1'b1;
                    end
                    if (w_last) begin
                        r_state      <= S_IDLE;
                        r_flush_pend <= 1'b0;
                        if (FLUSH || r_flush_pend)
                            r_valid <= '0;
                        else
                            r_valid[w_fidx] <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag and data are qualified by the valid bits, so they need no reset.
    always_ff @(posedge CLK) begin
        if (w_cap)
            r_data[w_fidx][w_cap_word] <= MEM_DI;
        if (w_last)
            r_tag[w_fidx] <= r_base[7:IW];
    end

endmodule

// File: doc/icache_fill_ctrl.md
# icache_fill_ctrl

Direct-mapped instruction cache with a pipelined line-fill state machine. It sits between the pipeline's IF stage (PC / IF-ID register) and the instruction memory. Hits return the instruction in the same cycle. Misses assert STALL, which the core uses to hold pc and IF/ID, while a 4-word line is fetched from I-memory. Hit and miss counters are exported for performance tests.

## Interface
Parameters:
- NUM_LINES, 8, number of cache lines; power of two, 2..64
- MEM_LAT, 1, I-memory read latency in cycles; ≥1

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RSTn  in  1  reset, asynchronous, active-low
- CORE_REQ  in  1  fetch request for CORE_ADDR this cycle
- CORE_ADDR  in  12  byte fetch address (pc); bits [1:0] ignored
- FLUSH  in  1  invalidate all lines (fence.i)
- CORE_INST  out  32  fetched instruction; 0 when CORE_VALID=0
- CORE_VALID  out  1  CORE_INST valid this cycle (hit)
- STALL  out  1  core must hold pc, IF/ID and CORE_ADDR
- MEM_CSN  out  1  I-memory chip select, active-low
- MEM_ADDR  out  12  I-memory byte address
- MEM_DI  in  32  I-memory data; returns the word for the address issued MEM_LAT cycles earlier
- HIT_CNT  out  16  saturating hit count
- MISS_CNT  out  16  saturating miss count

## Operation
- Address split: word = [3:2]; index = [3+log2(NUM_LINES):4]; tag = the remaining upper bits. With the default (8 lines): index [6:4], tag [11:7] (5 bits).
- Storage:
  - per line: valid bit, tag, 4×32 data
  - only valid bits are reset; tag and data arrays are not
- FSM states: IDLE, FILL.
- IDLE with CORE_REQ=0: CORE_VALID=0, STALL=0, no counter change.
- IDLE, CORE_REQ=1, valid[idx] and tag match (hit):
  - CORE_VALID=1 and CORE_INST=data[idx][word], combinationally in the same cycle
  - HIT_CNT+1
- IDLE, CORE_REQ=1, otherwise (miss):
  - STALL=1 combinationally
  - latch line base = {CORE_ADDR[11:4], 4'b0}
  - MISS_CNT+1; go to FILL
- FILL:
  - issue phase: on FILL cycles 0..3, MEM_CSN=0 and MEM_ADDR=base+4k
  - receive phase: capture MEM_DI into data[idx][k] on FILL cycle k+MEM_LAT
  - after word 3 is captured, write the tag, set the valid bit and return to IDLE
  - STALL=1 and CORE_VALID=0 for the whole of FILL
  - CORE_ADDR and CORE_REQ are ignored during FILL
- FLUSH:
  - in IDLE: all valid bits clear at the edge, and that cycle's lookup is treated as a miss
  - in FILL: the flush is recorded; the fill drains to completion, the line is not validated, and all valid bits clear on return to IDLE
- MEM_CSN=1 and MEM_ADDR holds its last value whenever no read is being issued.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values (while RSTn=0, asynchronous):
  - state IDLE, all valid bits 0, counters 0, recorded flush cleared
  - MEM_CSN=1, MEM_ADDR=0, CORE_VALID=0, STALL=0, CORE_INST=0
- Hit latency: 0 cycles, combinational from CORE_ADDR.
- Miss at cycle t:
  - address k (k=0..3) issued at cycle t+1+k
  - word k captured at the end of cycle t+1+k+MEM_LAT
  - IDLE at t+5+MEM_LAT, and the refetch hits that cycle
  - STALL high for cycles t..t+4+MEM_LAT, i.e. 5+MEM_LAT cycles (6 with default parameters)
- Issue and receive phases overlap; no more than 4 reads are in flight.
- Reset asserted mid-fill aborts immediately:
  - in-flight memory data is ignored after reset releases
  - the partially filled line stays invalid
- FLUSH and a miss in the same IDLE cycle: the flush applies first, then the fill proceeds normally and validates its line.

## Test plan
Memory model for all scenarios: MEM_DI = 32'hC0DE0000 | addr; default parameters.
- Cold miss: CORE_REQ=1, CORE_ADDR=0x004 after reset.
  - STALL high cycles 0..5, MEM_ADDR 0x000/0x004/0x008/0x00C on cycles 1..4
  - cycle 6: CORE_VALID=1, CORE_INST=0xC0DE0004; HIT_CNT=1, MISS_CNT=1
- Sequential line: after the fill, fetch 0x000, 0x008, 0x00C on consecutive cycles.
  - 3 hits, STALL=0 throughout, instructions 0xC0DE0000/..08/..0C
- Conflict: fetch 0x000 (filled), then 0x080 (same index 0, tag 1).
  - miss and refill; then 0x000 misses again
  - MISS_CNT increments on each miss
- FLUSH: with line 0 valid, pulse FLUSH in IDLE, then fetch 0x000.
  - miss; a 6-cycle STALL sequence repeats
  - FLUSH pulsed during FILL: the line is still invalid afterwards
- Reset mid-fill: deassert RSTn at FILL cycle 2.
  - MEM_CSN=1, STALL=0, counters 0 immediately
  - after release, fetch 0x000 misses
- Saturation: force 65 540 hits; HIT_CNT holds at 16'hFFFF.
